// File: rtl/signtrunc_pkg.sv
// Shared types, range constants and helpers for the signed word-to-immediate narrower.
package signtrunc_pkg;

   localparam int unsigned N_DEF = 16;
   localparam int unsigned I_DEF = 7;
   localparam int unsigned MAX_W = 64;

   localparam int IMM_MIN = -(2 ** (I_DEF - 1));
   localparam int IMM_MAX = (2 ** (I_DEF - 1)) - 1;

   // Buffer entry at the default immediate width; other widths use a same-shaped local type.
   typedef struct packed {
      logic [I_DEF-1:0] data;
      logic             ovf;
   } entry_t;

   // True when bits [nw-1:iw-1] of word all match the sign bit.
   function automatic logic fits(input logic [MAX_W-1:0] word, input int unsigned nw,
                                 input int unsigned iw);
      logic ok;
      ok = 1'b1;
      for (int unsigned k = 0; k < MAX_W; k++) begin
         if (k >= iw - 1 && k < nw && word[k] != word[nw-1]) ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic logic [MAX_W-1:0] sat_min(input int unsigned iw);
      logic [MAX_W-1:0] v;
      v = '0;
      v[iw-1] = 1'b1;
      return v;
   endfunction

   function automatic logic [MAX_W-1:0] sat_max(input int unsigned iw);
      logic [MAX_W-1:0] v;
      v = '0;
      for (int unsigned k = 0; k < MAX_W; k++) begin
         if (k < iw - 1) v[k] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/signtrunc_fifo2.sv
// Two-entry in-order buffer; slot0 is always the head so an emptied buffer keeps its last output.
module signtrunc_fifo2
   import signtrunc_pkg::*;
#(
   parameter type EntryT = entry_t
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  EntryT      in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output EntryT      out_data,
   output logic [1:0] occupancy
);

   EntryT      slot0_q, slot0_d, slot1_q, slot1_d;
   logic [1:0] count_q, count_d;
   logic       push, pop;

   assign in_ready  = (count_q < 2'd2) & ~reset;
   assign out_valid = (count_q != 2'd0);
   assign out_data  = slot0_q;
   assign occupancy = count_q;

   always_comb begin
      push    = in_valid & in_ready;
      pop     = out_valid & out_ready;
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      if (pop && count_q == 2'd2) slot0_d = slot1_q;
      if (push) begin
         if (count_q == 2'd0 || (count_q == 2'd1 && pop)) slot0_d = in_data;
         else slot1_d = in_data;
      end
      count_d = count_q + 2'(push) - 2'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= 2'd0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
      end
   end

   assert property (@(posedge clk) disable iff (reset)
      (out_valid && !out_ready) |=> $stable(out_data));

endmodule

// File: rtl/signtrunc.sv
// Narrows signed n-bit words to i-bit immediates, flags and counts unrepresentable values.
module signtrunc
   import signtrunc_pkg::*;
#(
   parameter int unsigned n   = N_DEF,
   parameter int unsigned i   = I_DEF,
   parameter int unsigned SAT = 1,
   parameter int unsigned CW  = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [n-1:0]  In,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [i-1:0]  Out,
   output logic          ovf,
   output logic [CW-1:0] ovf_count,
   input  logic          clr_count
);

   localparam int unsigned ImmW = i;

   typedef struct packed {
      logic [i-1:0] data;
      logic         ovf;
   } imm_entry_t;

   logic [MAX_W-1:0] in_ext;
   logic             in_fits;
   logic             push;
   imm_entry_t       narrow, head;
   logic [1:0]       occupancy;
   logic [CW-1:0]    ovf_count_q, ovf_count_d;

   always_comb begin
      in_ext         = '0;
      in_ext[n-1:0]  = In;
      in_fits        = fits(in_ext, n, i);
      narrow.data    = In[i-1:0];
      narrow.ovf     = ~in_fits;
      if (!in_fits && SAT != 0) begin
         narrow.data = In[n-1] ? ImmW'(sat_min(i)) : ImmW'(sat_max(i));
      end
   end

   signtrunc_fifo2 #(
      .EntryT(imm_entry_t)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (narrow),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head),
      .occupancy (occupancy)
   );

   assign Out = head.data;
   assign ovf = head.ovf;
   assign push = in_valid & in_ready;

   // Clear wins over a same-cycle increment; the count sticks at all-ones.
   always_comb begin
      ovf_count_d = ovf_count_q;
      if (clr_count) ovf_count_d = '0;
      else if (push && narrow.ovf && ovf_count_q != '1) ovf_count_d = ovf_count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) ovf_count_q <= '0;
      else ovf_count_q <= ovf_count_d;
   end

   assign ovf_count = ovf_count_q;

   assert property (@(posedge clk) disable iff (reset) occupancy <= 2'd2);

endmodule

// File: tb/tb_signtrunc.sv
// Scoreboarded bench: saturating (default), wrapping and 2-bit-counter instances share stimulus.
module tb_signtrunc;

   logic        clk = 1'b0;
   logic        reset, in_valid, out_ready, clr_count;
   logic [15:0] in_word;

   logic        a_in_ready, a_out_valid, a_ovf;
   logic [6:0]  a_out;
   logic [15:0] a_count;
   logic        w_in_ready, w_out_valid, w_ovf;
   logic [6:0]  w_out;
   logic [15:0] w_count;
   logic        c_in_ready, c_out_valid, c_ovf;
   logic [6:0]  c_out;
   logic [1:0]  c_count;

   int checks   = 0;
   int failures = 0;

   logic [7:0] qa[$];
   logic [7:0] qw[$];
   logic [7:0] qc[$];

   always #5 clk = ~clk;

   signtrunc u_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready), .In(in_word),
      .out_valid(a_out_valid), .out_ready(out_ready), .Out(a_out), .ovf(a_ovf),
      .ovf_count(a_count), .clr_count(clr_count)
   );

   signtrunc #(.SAT(0)) u_w (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready), .In(in_word),
      .out_valid(w_out_valid), .out_ready(out_ready), .Out(w_out), .ovf(w_ovf),
      .ovf_count(w_count), .clr_count(clr_count)
   );

   signtrunc #(.CW(2)) u_c (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready), .In(in_word),
      .out_valid(c_out_valid), .out_ready(out_ready), .Out(c_out), .ovf(c_ovf),
      .ovf_count(c_count), .clr_count(clr_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic extra(input string name, input logic [31:0] act);
      checks++;
      failures++;
      $display("FAIL %s: unexpected output 0x%0h with empty scoreboard", name, act);
   endtask

   // Monitor: compare every output that will be popped at the coming edge.
   always @(negedge clk) begin
      if (!reset && out_ready) begin
         if (a_out_valid) begin
            if (qa.size() == 0) extra("sat_out", {24'd0, a_ovf, a_out});
            else check("sat_out", {24'd0, a_ovf, a_out}, {24'd0, qa.pop_front()});
         end
         if (w_out_valid) begin
            if (qw.size() == 0) extra("wrap_out", {24'd0, w_ovf, w_out});
            else check("wrap_out", {24'd0, w_ovf, w_out}, {24'd0, qw.pop_front()});
         end
         if (c_out_valid) begin
            if (qc.size() == 0) extra("cnt2_out", {24'd0, c_ovf, c_out});
            else check("cnt2_out", {24'd0, c_ovf, c_out}, {24'd0, qc.pop_front()});
         end
      end
   end

   // ea = {ovf, saturated Out}; ew = {ovf, wrapped Out}.
   task automatic push(input logic [15:0] x, input logic [7:0] ea, input logic [7:0] ew);
      int cyc;
      cyc      = 0;
      in_valid = 1'b1;
      in_word  = x;
      while (!a_in_ready && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!a_in_ready) begin
         check("push_timeout", 32'(a_in_ready), 32'd1);
         in_valid = 1'b0;
      end else begin
         qa.push_back(ea);
         qw.push_back(ew);
         qc.push_back(ea);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_word   = '0;
      out_ready = 1'b1;
      clr_count = 1'b0;
      idle(2);
      check("rst_in_ready", 32'(a_in_ready), 32'd0);
      check("rst_out_valid", 32'(a_out_valid), 32'd0);
      check("rst_out", {24'd0, a_ovf, a_out}, 32'd0);
      check("rst_count", 32'(a_count), 32'd0);
      reset = 1'b0;
      #1;
      check("in_ready_after_rst", 32'(a_in_ready), 32'd1);

      // Range edges: both fit.
      push(16'h003F, 8'h3F, 8'h3F);
      check("latency_valid", 32'(a_out_valid), 32'd1);
      check("latency_out", 32'(a_out), 32'h3F);
      push(16'hFFC0, 8'h40, 8'h40);
      idle(1);
      check("edge_count", 32'(a_count), 32'd0);

      // Overflow: clamp vs wrap; 2-bit counter saturates at 3.
      push(16'h0040, 8'hBF, 8'hC0);
      push(16'h8000, 8'hC0, 8'h80);
      push(16'h7FFF, 8'hBF, 8'hFF);
      check("ovf_count3", 32'(a_count), 32'd3);
      check("cnt2_count3", 32'(c_count), 32'd3);
      push(16'hFF7F, 8'hC0, 8'hFF);
      push(16'h0040, 8'hBF, 8'hC0);
      check("ovf_count5", 32'(a_count), 32'd5);
      check("wrap_count5", 32'(w_count), 32'd5);
      check("cnt2_saturated", 32'(c_count), 32'd3);

      // Clear wins over a same-cycle overflowing push.
      clr_count = 1'b1;
      push(16'h8000, 8'hC0, 8'h80);
      clr_count = 1'b0;
      check("clr_count", 32'(a_count), 32'd0);
      check("cnt2_clr", 32'(c_count), 32'd0);
      idle(3);

      // Backpressure.
      out_ready = 1'b0;
      push(16'h0001, 8'h01, 8'h01);
      push(16'h0002, 8'h02, 8'h02);
      check("full_in_ready", 32'(a_in_ready), 32'd0);
      in_valid = 1'b1;
      in_word  = 16'h0003;
      idle(2);
      check("held_in_ready", 32'(a_in_ready), 32'd0);
      check("held_head", {24'd0, a_ovf, a_out}, 32'h01);
      out_ready = 1'b1;
      idle(1);
      check("full_pop_only", 32'(a_in_ready), 32'd1);
      check("full_pop_head", 32'(a_out), 32'h02);
      push(16'h0003, 8'h03, 8'h03);
      idle(3);
      check("drained_valid", 32'(a_out_valid), 32'd0);

      // Reset mid-stream.
      out_ready = 1'b0;
      push(16'h0040, 8'hBF, 8'hC0);
      push(16'h8000, 8'hC0, 8'h80);
      check("pre_rst_count", 32'(a_count), 32'd2);
      check("pre_rst_valid", 32'(a_out_valid), 32'd1);
      reset = 1'b1;
      qa.delete();
      qw.delete();
      qc.delete();
      idle(1);
      check("mid_rst_valid", 32'(a_out_valid), 32'd0);
      check("mid_rst_out", {24'd0, a_ovf, a_out}, 32'd0);
      check("mid_rst_wrap_out", {24'd0, w_ovf, w_out}, 32'd0);
      check("mid_rst_count", 32'(a_count), 32'd0);
      check("mid_rst_cnt2", 32'(c_count), 32'd0);
      check("mid_rst_in_ready", 32'(a_in_ready), 32'd0);
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(a_in_ready), 32'd1);
      out_ready = 1'b1;
      push(16'h0005, 8'h05, 8'h05);
      check("post_rst_out", {24'd0, a_ovf, a_out}, 32'h05);
      idle(4);
      check("sb_sat_empty", 32'(qa.size()), 32'd0);
      check("sb_wrap_empty", 32'(qw.size()), 32'd0);
      check("sb_cnt2_empty", 32'(qc.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
